m2_idct_block_scheduler: RTL
============================

Name: m2_idct_block_scheduler

Overview:
- Top-level sequencer for the Milestone 2 IDCT datapath.
- Walks every 8x8 block of the Y, U and V pre-IDCT coefficient segments in SRAM, in raster order.
- Issues start pulses and block base addresses to four sub-engines: S' fetch, compute T, compute S, S write.
- Overlaps fetch of block k+1 with compute-S of block k, and write of block k with compute-T of block k+1.

Parameters:
- Y_BLK_COLS, 40, Y blocks per block-row (320 px / 8)
- UV_BLK_COLS, 20, U/V blocks per block-row (160 px / 8)
- BLK_ROWS, 30, block-rows per segment (240 px / 8)
- PRE_BASE_Y, 76800, pre-IDCT Y segment base address
- PRE_BASE_U, 153600, pre-IDCT U segment base address
- PRE_BASE_V, 192000, pre-IDCT V segment base address
- POST_BASE_Y, 0, output Y base address
- POST_BASE_U, 38400, output U base address
- POST_BASE_V, 57600, output V base address

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous reset, active-high
- Enable  in  1  level; starts a frame when sampled high in IDLE
- fetch_start  out  1  one-cycle pulse: fetch S' block into DPRAM
- fetch_addr  out  18  SRAM address of top-left coefficient of fetch block
- fetch_stride  out  9  SRAM words per coefficient row (320 Y, 160 U/V)
- fetch_done  in  1  one-cycle pulse from fetch engine
- ct_start  out  1  pulse: compute T = S'·C
- ct_done  in  1  pulse
- cs_start  out  1  pulse: compute S = Cᵀ·T
- cs_done  in  1  pulse
- write_start  out  1  pulse: write S block to SRAM
- write_addr  out  18  SRAM address of top-left output word (2 px/word)
- write_stride  out  9  output words per row (160 Y, 80 U/V)
- write_done  in  1  pulse
- busy  out  1  high from frame start until finish
- finish  out  1  one-cycle pulse when the last write completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; both block counters at (seg=Y, brow=0, bcol=0); pending flags cleared.
- Counters: fetch counter F and write counter W, each holding (seg, brow, bcol).
  - A counter advances in the same cycle its start pulse is issued.
  - bcol increments; at the segment's column limit it wraps to 0 and brow increments.
  - At brow = BLK_ROWS-1 wrap, the counter moves to the next segment (Y → U → V).
  - After the final V block the counter sets a last flag.
- Address calculation, registered together with the start pulse:
  - fetch_addr = PRE_BASE_seg + brow*8*stride + bcol*8
  - write_addr = POST_BASE_seg + brow*8*wstride + bcol*4
- Start pulses are registered and high for exactly the first cycle of the state that issues them. Address and stride outputs hold their values until the next start pulse of the same engine.
- States and transitions:
  - IDLE: Enable=1 → LI_FETCH (fetch_start, busy←1).
  - LI_FETCH: on fetch_done → LI_CT (ct_start).
  - LI_CT: on ct_done → CS_FS (cs_start and fetch_start issued together).
  - CS_FS: wait for both cs_done and fetch_done, in either order or the same cycle. Each done sets its pending-complete flag. When both flags are set → CT_WS (ct_start and write_start together); flags clear.
  - CT_WS: wait for both ct_done and write_done.
    - If F.last is not set → CS_FS.
    - If F.last is set → LO_CS (cs_start).
  - LO_CS: on cs_done → LO_WS (write_start).
  - LO_WS: on write_done → IDLE; finish pulses for 1 cycle; busy←0; counters reset.
- Latency: exactly one cycle from the last required done pulse (sampled at edge N) to the next start pulse (high during cycle N+1).
- Done pulses arriving in a state that does not wait for that engine are ignored. A duplicate done is idempotent.
- Enable is ignored while busy. If Enable is still high on return to IDLE, a new frame starts the next cycle.
- Reset mid-frame forces IDLE immediately; no start pulse is emitted during or on the cycle after reset release.
- Totals per frame: 2400 fetch_start, ct_start, cs_start and write_start pulses each; one finish pulse.

Test Plan:
- Reset then Enable=1 with zero-latency done responders → first fetch_start with fetch_addr=76800, fetch_stride=320; second fetch_addr=76808; first write_addr=0, write_stride=160; second write_addr=4.
- Block 40 (Y brow1 bcol0) → fetch_addr=79360, write_addr=1280; block 1200 → fetch_addr=153600 stride 160, write_addr=38400 stride 80; block 1800 → fetch_addr=192000, write_addr=57600.
- Last block (V brow29 bcol19) → fetch_addr=229272, write_addr=76236. After its write_done, finish pulses once and busy falls. Count exactly 2400 pulses per engine.
- In CS_FS, deliver fetch_done 10 cycles before cs_done, then reversed, then both in the same cycle → ct_start and write_start rise exactly 1 cycle after the later done, every time.
- Stray ct_done during CS_FS plus a duplicate fetch_done → no state change, no extra pulses, address sequence unaffected.
- Assert Reset during CT_WS of block 500 → all outputs 0 at once. Release Reset with Enable=1 → frame restarts with fetch_addr=76800.

Source files
------------

// File: rtl/m2_idct_block_scheduler.sv
// Top-level sequencer for the Milestone 2 IDCT datapath: walks every 8x8 block of Y, U, V
// and overlaps S' fetch / compute T / compute S / S write across consecutive blocks.
module m2_idct_block_scheduler #(
  parameter int Y_BLK_COLS  = 40,
  parameter int UV_BLK_COLS = 20,
  parameter int BLK_ROWS    = 30,
  parameter int PRE_BASE_Y  = 76800,
  parameter int PRE_BASE_U  = 153600,
  parameter int PRE_BASE_V  = 192000,
  parameter int POST_BASE_Y = 0,
  parameter int POST_BASE_U = 38400,
  parameter int POST_BASE_V = 57600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        fetch_start,
  output logic [17:0] fetch_addr,
  output logic [8:0]  fetch_stride,
  input  logic        fetch_done,
  output logic        ct_start,
  input  logic        ct_done,
  output logic        cs_start,
  input  logic        cs_done,
  output logic        write_start,
  output logic [17:0] write_addr,
  output logic [8:0]  write_stride,
  input  logic        write_done,
  output logic        busy,
  output logic        finish
);

  typedef enum logic [2:0] {IDLE, LI_FETCH, LI_CT, CS_FS, CT_WS, LO_CS, LO_WS} state_t;
  typedef struct packed {
    logic [1:0] seg;
    logic [4:0] brow;
    logic [5:0] bcol;
  } blk_t;

  localparam logic [1:0] SEG_Y = 2'd0;
  localparam logic [1:0] SEG_U = 2'd1;
  localparam logic [1:0] SEG_V = 2'd2;

  state_t state;
  blk_t   f_ctr, w_ctr;
  logic   f_last, pend_a, pend_b, armed;
  logic   done_a, done_b, pair_done, fetch_go, write_go, frame_end;

  function automatic logic [5:0] cols_of(input logic [1:0] seg);
    return (seg == SEG_Y) ? 6'(Y_BLK_COLS) : 6'(UV_BLK_COLS);
  endfunction

  function automatic blk_t advance(input blk_t b);
    blk_t n;
    n = b;
    if (b.bcol == cols_of(b.seg) - 6'd1) begin
      n.bcol = '0;
      if (b.brow == 5'(BLK_ROWS - 1)) begin
        n.brow = '0;
        n.seg  = (b.seg == SEG_V) ? SEG_Y : b.seg + 2'd1;
      end else begin
        n.brow = b.brow + 5'd1;
      end
    end else begin
      n.bcol = b.bcol + 6'd1;
    end
    return n;
  endfunction

  function automatic logic is_final(input blk_t b);
    return (b.seg == SEG_V) && (b.brow == 5'(BLK_ROWS - 1)) && (b.bcol == 6'(UV_BLK_COLS - 1));
  endfunction

  function automatic logic [8:0] fstride_of(input logic [1:0] seg);
    return (seg == SEG_Y) ? 9'(Y_BLK_COLS * 8) : 9'(UV_BLK_COLS * 8);
  endfunction

  function automatic logic [8:0] wstride_of(input logic [1:0] seg);
    return (seg == SEG_Y) ? 9'(Y_BLK_COLS * 4) : 9'(UV_BLK_COLS * 4);
  endfunction

  function automatic logic [17:0] faddr_of(input blk_t b);
    logic [17:0] base;
    base = (b.seg == SEG_Y) ? 18'(PRE_BASE_Y) : (b.seg == SEG_U) ? 18'(PRE_BASE_U) : 18'(PRE_BASE_V);
    return base + ((18'(b.brow) * 18'(fstride_of(b.seg))) << 3) + (18'(b.bcol) << 3);
  endfunction

  // Output words pack two pixels, so a block column advances by 4 words rather than 8.
  function automatic logic [17:0] waddr_of(input blk_t b);
    logic [17:0] base;
    base = (b.seg == SEG_Y) ? 18'(POST_BASE_Y) : (b.seg == SEG_U) ? 18'(POST_BASE_U) : 18'(POST_BASE_V);
    return base + ((18'(b.brow) * 18'(wstride_of(b.seg))) << 3) + (18'(b.bcol) << 2);
  endfunction

  always_comb begin
    done_a = 1'b0;
    done_b = 1'b0;
    case (state)
      CS_FS: begin done_a = cs_done; done_b = fetch_done; end
      CT_WS: begin done_a = ct_done; done_b = write_done; end
      default: ;
    endcase
    pair_done = (pend_a | done_a) & (pend_b | done_b);
    fetch_go  = (state == IDLE && enable && armed) || (state == LI_CT && ct_done) ||
                (state == CT_WS && pair_done && !f_last);
    write_go  = (state == CS_FS && pair_done) || (state == LO_CS && cs_done);
    frame_end = (state == LO_WS) && write_done;
  end

  // armed holds off a frame start for the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      fetch_start <= 1'b0;
      ct_start    <= 1'b0;
      cs_start    <= 1'b0;
      write_start <= 1'b0;
    end else begin
      armed       <= 1'b1;
      fetch_start <= fetch_go;
      write_start <= write_go;
      ct_start    <= 1'b0;
      cs_start    <= 1'b0;
      finish      <= 1'b0;
      case (state)
        IDLE: if (fetch_go) begin
          busy  <= 1'b1;
          state <= LI_FETCH;
        end
        LI_FETCH: if (fetch_done) begin
          ct_start <= 1'b1;
          state    <= LI_CT;
        end
        LI_CT: if (ct_done) begin
          cs_start <= 1'b1;
          state    <= CS_FS;
        end
        CS_FS: if (pair_done) begin
          pend_a   <= 1'b0;
          pend_b   <= 1'b0;
          ct_start <= 1'b1;
          state    <= CT_WS;
        end else begin
          pend_a <= pend_a | done_a;
          pend_b <= pend_b | done_b;
        end
        CT_WS: if (pair_done) begin
          pend_a   <= 1'b0;
          pend_b   <= 1'b0;
          cs_start <= 1'b1;
          state    <= f_last ? LO_CS : CS_FS;
        end else begin
          pend_a <= pend_a | done_a;
          pend_b <= pend_b | done_b;
        end
        LO_CS: if (cs_done) state <= LO_WS;
        LO_WS: if (write_done) begin
          finish <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_ctr        <= '0;
      w_ctr        <= '0;
      f_last       <= 1'b0;
      fetch_addr   <= '0;
      fetch_stride <= '0;
      write_addr   <= '0;
      write_stride <= '0;
    end else if (frame_end) begin
      f_ctr  <= '0;
      w_ctr  <= '0;
      f_last <= 1'b0;
    end else begin
      if (fetch_go) begin
        fetch_addr   <= faddr_of(f_ctr);
        fetch_stride <= fstride_of(f_ctr.seg);
        f_ctr        <= advance(f_ctr);
        if (is_final(f_ctr)) f_last <= 1'b1;
      end
      if (write_go) begin
        write_addr   <= waddr_of(w_ctr);
        write_stride <= wstride_of(w_ctr.seg);
        w_ctr        <= advance(w_ctr);
      end
    end
  end

endmodule
